// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller:
// FSM states, forwarding select codes and the scoreboard slot layout.
package pipeline_controller_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int WB_SEL_LOAD = 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
        logic       is_mem;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // near = slot that will sit in MEM next cycle, far = slot that will sit in WB.
    function automatic logic [1:0] fwd_code(input logic [4:0] rs, input slot_t near, input slot_t far);
        logic [1:0] code;
        code = FWD_RF;
        if (rs != 5'd0) begin
            if (near.valid && near.we && (near.rd == rs)) begin
                code = FWD_MEM;
            end else if (far.valid && far.we && (far.rd == rs)) begin
                code = FWD_WB;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/pipeline_controller_hazard_scoreboard.sv
// EX/MEM/WB destination scoreboard: shifts on every advance, detects
// load-use hazards at ID and registers the EX operand forwarding selects.
module pipeline_controller_hazard_scoreboard
    import pipeline_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        bubble,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_wb_we,
    input  logic        id_is_load,
    input  logic        id_mem,
    output logic        ex_valid,
    output logic        mem_busy,
    output logic        load_use,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [26:0] slots
);

    slot_t ex_q, mem_q, wb_q, id_slot;
    logic  rs1_hit, rs2_hit;

    always_comb begin
        id_slot = SLOT_EMPTY;
        if (id_valid) begin
            id_slot.valid   = 1'b1;
            id_slot.rd      = id_rd;
            id_slot.we      = id_wb_we && (id_rd != 5'd0);
            id_slot.is_load = id_is_load;
            id_slot.is_mem  = id_mem;
        end
    end

    // ex_q.we already implies rd != 0, so x0 never causes a stall.
    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_q.rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_q.rd);
    assign load_use = id_valid && ex_q.valid && ex_q.we && ex_q.is_load && (rs1_hit || rs2_hit);

    assign ex_valid = ex_q.valid;
    assign mem_busy = mem_q.valid && mem_q.is_mem;
    assign slots    = {ex_q, mem_q, wb_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q      <= SLOT_EMPTY;
            mem_q     <= SLOT_EMPTY;
            wb_q      <= SLOT_EMPTY;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (advance) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble || !id_valid) begin
                ex_q      <= SLOT_EMPTY;
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                ex_q      <= id_slot;
                fwd_a_sel <= fwd_code(id_rs1, ex_q, mem_q);
                fwd_b_sel <= fwd_code(id_rs2, ex_q, mem_q);
            end
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller: memory-wait freeze, branch redirect flush,
// load-use stall, forwarding selects and a stall-cycle performance counter.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_wb_we,
    input  logic [2:0]       i_id_wb_sel,
    input  logic             i_id_mem,
    input  logic             i_ex_redirect,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_pipe_en,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_dbg_state,
    output logic [26:0]      o_dbg_slots
);

    state_t state, state_next;
    logic   ex_valid, mem_busy, load_use, frozen;
    logic   unused_wb_sel;

    assign unused_wb_sel = ^{i_id_wb_sel[2], i_id_wb_sel[0]};

    pipeline_controller_hazard_scoreboard u_scoreboard (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .advance    (o_pipe_en),
        .bubble     (o_idex_bubble),
        .id_valid   (i_id_valid),
        .id_rs1     (i_id_rs1),
        .id_rs2     (i_id_rs2),
        .id_use_rs1 (i_id_use_rs1),
        .id_use_rs2 (i_id_use_rs2),
        .id_rd      (i_id_rd),
        .id_wb_we   (i_id_wb_we),
        .id_is_load (i_id_wb_sel[WB_SEL_LOAD]),
        .id_mem     (i_id_mem),
        .ex_valid   (ex_valid),
        .mem_busy   (mem_busy),
        .load_use   (load_use),
        .fwd_a_sel  (o_fwd_a_sel),
        .fwd_b_sel  (o_fwd_b_sel),
        .slots      (o_dbg_slots)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_RUN;
            o_stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (!o_pc_en) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
        end
    end

    // The ready response is used in the same cycle, so the cycle in which
    // i_mem_ready rises is already a normal (possibly redirecting) cycle.
    always_comb begin
        state_next    = state;
        frozen        = 1'b0;
        o_pc_en       = 1'b1;
        o_ifid_en     = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_en     = 1'b1;
        case (state)
            ST_RUN: begin
                frozen = mem_busy && !i_mem_ready;
                if (frozen) state_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                frozen = !i_mem_ready;
                if (i_mem_ready) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
        if (frozen) begin
            o_pc_en   = 1'b0;
            o_ifid_en = 1'b0;
            o_pipe_en = 1'b0;
        end else if (i_ex_redirect && ex_valid) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (load_use) begin
            o_pc_en       = 1'b0;
            o_ifid_en     = 1'b0;
            o_idex_bubble = 1'b1;
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: reset, forwarding, load-use,
// redirect, memory wait with pending redirect, x0 handling, reset mid-stall.
module tb_pipeline_controller;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_id_valid;
    logic [4:0]  i_id_rs1, i_id_rs2, i_id_rd;
    logic        i_id_use_rs1, i_id_use_rs2, i_id_wb_we, i_id_mem;
    logic [2:0]  i_id_wb_sel;
    logic        i_ex_redirect, i_mem_ready;
    logic        o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_pipe_en;
    logic [1:0]  o_fwd_a_sel, o_fwd_b_sel;
    logic [31:0] o_stall_cnt;
    logic        o_dbg_state;
    logic [26:0] o_dbg_slots;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    pipeline_controller #(.CNT_W(32)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_id_valid    (i_id_valid),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .i_id_rd       (i_id_rd),
        .i_id_wb_we    (i_id_wb_we),
        .i_id_wb_sel   (i_id_wb_sel),
        .i_id_mem      (i_id_mem),
        .i_ex_redirect (i_ex_redirect),
        .i_mem_ready   (i_mem_ready),
        .o_pc_en       (o_pc_en),
        .o_ifid_en     (o_ifid_en),
        .o_ifid_flush  (o_ifid_flush),
        .o_idex_bubble (o_idex_bubble),
        .o_pipe_en     (o_pipe_en),
        .o_fwd_a_sel   (o_fwd_a_sel),
        .o_fwd_b_sel   (o_fwd_b_sel),
        .o_stall_cnt   (o_stall_cnt),
        .o_dbg_state   (o_dbg_state),
        .o_dbg_slots   (o_dbg_slots)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_en(input string tag, input logic pc, input logic ifid, input logic flush,
                            input logic bub, input logic pipe);
        check({tag, "_pc_en"},     32'(o_pc_en),       32'(pc));
        check({tag, "_ifid_en"},   32'(o_ifid_en),     32'(ifid));
        check({tag, "_flush"},     32'(o_ifid_flush),  32'(flush));
        check({tag, "_bubble"},    32'(o_idex_bubble), 32'(bub));
        check({tag, "_pipe_en"},   32'(o_pipe_en),     32'(pipe));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic we, input logic [2:0] sel,
                          input logic mem);
        i_id_valid   = v;
        i_id_rs1     = rs1;
        i_id_rs2     = rs2;
        i_id_use_rs1 = u1;
        i_id_use_rs2 = u2;
        i_id_rd      = rd;
        i_id_wb_we   = we;
        i_id_wb_sel  = sel;
        i_id_mem     = mem;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        // Reset held for 3 cycles with a load and a redirect driven at the inputs.
        i_rst_n       = 1'b0;
        i_ex_redirect = 1'b1;
        i_mem_ready   = 1'b0;
        set_id(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 1'b1, 1'b1,
               5'($urandom_range(1, 31)), 1'b1, 3'b010, 1'b1);
        repeat (3) tick();
        i_rst_n       = 1'b1;
        i_ex_redirect = 1'b0;
        i_mem_ready   = 1'b1;
        nop();
        settle();
        check_en("reset", 1, 1, 0, 0, 1);
        check("reset_fwd_a", 32'(o_fwd_a_sel), 32'd0);
        check("reset_fwd_b", 32'(o_fwd_b_sel), 32'd0);
        check("reset_cnt", o_stall_cnt, 32'd0);
        check("reset_state", 32'(o_dbg_state), 32'd0);
        check("reset_slots", 32'(o_dbg_slots), 32'd0);

        // add x5,x1,x2 then sub x6,x5,x1: EX->MEM forward on A, no stall.
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 3'b001, 0);
        settle();
        check_en("add5", 1, 1, 0, 0, 1);
        tick();
        set_id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 3'b001, 0);
        settle();
        check_en("sub6", 1, 1, 0, 0, 1);
        tick();
        check("sub6_fwd_a", 32'(o_fwd_a_sel), 32'd1);
        check("sub6_fwd_b", 32'(o_fwd_b_sel), 32'd0);
        check("sub6_cnt", o_stall_cnt, 32'd0);

        // lw x7,0(x1) then add x8,x7,x7: one bubble, then WB forward on both.
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 3'b010, 1);
        settle();
        check_en("lw7", 1, 1, 0, 0, 1);
        tick();
        check("lw7_fwd_a", 32'(o_fwd_a_sel), 32'd0);
        set_id(1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 3'b001, 0);
        settle();
        check_en("loaduse", 0, 0, 0, 1, 1);
        tick();
        check("loaduse_bubble_fwd_a", 32'(o_fwd_a_sel), 32'd0);
        check("loaduse_cnt", o_stall_cnt, 32'd1);
        settle();
        check_en("loaduse_release", 1, 1, 0, 0, 1);
        tick();
        check("add8_fwd_a", 32'(o_fwd_a_sel), 32'd2);
        check("add8_fwd_b", 32'(o_fwd_b_sel), 32'd2);
        check("add8_cnt", o_stall_cnt, 32'd1);

        // beq taken in EX: flush + bubble for one cycle, next two EX slots empty.
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 3'b000, 0);
        tick();
        set_id(1, 5'd1, 5'd1, 1, 1, 5'd9, 1, 3'b001, 0);
        i_ex_redirect = 1'b1;
        settle();
        check_en("redir", 1, 1, 1, 1, 1);
        tick();
        check("redir_ex1_valid", 32'(o_dbg_slots[26]), 32'd0);
        nop();
        settle();
        check_en("redir_stray1", 1, 1, 0, 0, 1);
        tick();
        check("redir_ex2_valid", 32'(o_dbg_slots[26]), 32'd0);
        check("redir_mem_valid", 32'(o_dbg_slots[17]), 32'd0);
        settle();
        check_en("redir_stray2", 1, 1, 0, 0, 1);
        i_ex_redirect = 1'b0;
        check("redir_cnt", o_stall_cnt, 32'd1);

        // add x3; sw x3,0(x4); beq x3,x0 in EX while sw waits 4 cycles in MEM.
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 3'b001, 0);
        tick();
        set_id(1, 5'd4, 5'd3, 1, 1, 5'd0, 0, 3'b000, 1);
        tick();
        check("sw_fwd_a", 32'(o_fwd_a_sel), 32'd0);
        check("sw_fwd_b", 32'(o_fwd_b_sel), 32'd1);
        set_id(1, 5'd3, 5'd0, 1, 1, 5'd0, 0, 3'b000, 0);
        tick();
        check("beq_fwd_a", 32'(o_fwd_a_sel), 32'd2);
        check("beq_fwd_b", 32'(o_fwd_b_sel), 32'd0);
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 3'b001, 0);
        i_mem_ready   = 1'b0;
        i_ex_redirect = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_en($sformatf("memwait%0d", k), 0, 0, 0, 0, 0);
            check($sformatf("memwait%0d_fwd_a", k), 32'(o_fwd_a_sel), 32'd2);
            tick();
        end
        check("memwait_state", 32'(o_dbg_state), 32'd1);
        check("memwait_cnt", o_stall_cnt, 32'd5);
        i_mem_ready = 1'b1;
        settle();
        check_en("memdone_redir", 1, 1, 1, 1, 1);
        tick();
        check("memdone_state", 32'(o_dbg_state), 32'd0);
        check("memdone_cnt", o_stall_cnt, 32'd5);
        check("memdone_fwd_a", 32'(o_fwd_a_sel), 32'd0);
        i_ex_redirect = 1'b0;

        // Writes to x0 (including a load) followed by reads of x0.
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 3'b001, 0);
        tick();
        set_id(1, 5'd2, 5'd0, 1, 0, 5'd0, 1, 3'b010, 1);
        settle();
        check_en("x0_lw", 1, 1, 0, 0, 1);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd12, 1, 3'b001, 0);
        settle();
        check_en("x0_read", 1, 1, 0, 0, 1);
        tick();
        check("x0_fwd_a", 32'(o_fwd_a_sel), 32'd0);
        check("x0_fwd_b", 32'(o_fwd_b_sel), 32'd0);
        check("x0_cnt", o_stall_cnt, 32'd5);

        // Reset while frozen on a store: back to RUN with an empty scoreboard.
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 3'b000, 1);
        tick();
        nop();
        tick();
        i_mem_ready = 1'b0;
        settle();
        check_en("rststall_frozen", 0, 0, 0, 0, 0);
        tick();
        check("rststall_state", 32'(o_dbg_state), 32'd1);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        settle();
        check_en("rststall_after", 1, 1, 0, 0, 1);
        check("rststall_after_state", 32'(o_dbg_state), 32'd0);
        check("rststall_after_slots", 32'(o_dbg_slots), 32'd0);
        check("rststall_after_cnt", o_stall_cnt, 32'd0);
        tick();
        check("rststall_run_state", 32'(o_dbg_state), 32'd0);
        check("rststall_run_cnt", o_stall_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
